int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller that drives the next-PC unit's interrupt inputs: int_signal, int_pend (vector select) and sepc (return address).
- Latches external IRQ edges, applies global enable and a per-line mask, and priority-encodes the highest request.
- Fires only at a pipeline-safe point and keeps a nesting stack of return PCs and in-service levels, which is popped by the return instruction.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; line index = priority (7 highest); int_pend width = log2(NUM_IRQ).
- DEPTH, 8, nesting-stack entries; must be >= NUM_IRQ, so the stack can never overflow.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, level inputs, rising-edge detected.
- int_en  in  1  global interrupt enable.
- int_mask  in  NUM_IRQ  per-line enable (1 = enabled).
- ex_pc  in  32  PC of the oldest unretired instruction; saved as the return address.
- can_take  in  1  pipeline safe point: no stall, no unresolved branch/jump this cycle.
- eret  in  1  one-cycle pulse when the return instruction redirects the PC to sepc.
- int_signal  out  1  one-cycle pulse: redirect the PC to the vector for int_pend.
- int_pend  out  3  id of the interrupt being taken; valid while int_signal = 1.
- sepc  out  32  top-of-stack return PC; 0 when the stack is empty.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse, coincident with int_signal.
- in_service  out  NUM_IRQ  bitmap of active (nested) levels.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (rstn = 0 at a clk edge) clears everything in that cycle and aborts any operation in progress:
  - pending register, edge-detect history, stack and depth counter go to 0;
  - FSM goes to IDLE;
  - int_signal, int_pend, sepc, irq_ack, in_service and busy all go to 0.
- Edge detect:
  - pending[i] is set the cycle after irq_in[i] goes 0 -> 1 (registered history).
  - It is cleared only when that line is taken. Masking does not clear it.
  - A set and a clear on the same cycle resolve to set.
- Eligibility:
  - eligible = pending & int_mask, gated by int_en.
  - best = highest eligible index.
  - cur = highest set bit of in_service, or -1 when none is set.
  - A request exists when some line is eligible and best > cur (strict preemption only).
- FSM states:
  - IDLE: on a request and eret = 0, go to WAIT.
  - WAIT:
    - If the request vanishes (masked or disabled), return to IDLE.
    - Else if can_take = 1 and eret = 0: latch id = best (re-evaluated this cycle), push {ex_pc, id}, set in_service[id], clear pending[id], go to FIRE.
  - FIRE: int_signal = 1, int_pend = id, irq_ack[id] = 1, sepc = ex_pc just pushed; next cycle go to IDLE.
- Latency: with can_take held at 1, the interrupt fires 2 cycles after the pending bit is set.
- eret:
  - If depth > 0: pop, clear in_service for the popped id, and sepc shows the new top (0 if empty) from the next cycle.
  - If depth = 0: no effect.
  - eret blocks IDLE->WAIT and WAIT->FIRE in the same cycle; the pop wins and the request is re-evaluated next cycle.
  - eret during FIRE is a protocol error; it is ignored and the bench asserts it never occurs.
- Boundary conditions:
  - Depth saturates at DEPTH; a push at full is impossible by construction and is asserted.
  - A re-raised irq for a line already in service stays pending until the level drops below it.

Decomposition:
- Shared package/defines file:
  - FSM state encodings IDLE / WAIT / FIRE;
  - NUM_IRQ default;
  - vector stride constant (24 bytes), used by the next-PC unit.
- One sub-module: int_prio_enc, a combinational highest-set-bit encoder returning {valid, index}. It is instantiated twice, once for best and once for cur.

Test Plan:
- Single IRQ: irq_in[3] rises, mask = 0xFF, int_en = 1, can_take = 1, ex_pc = 0x100 -> int_signal pulses with int_pend = 3, irq_ack = 0x08, sepc = 0x100, in_service = 0x08; eret -> sepc = 0, in_service = 0.
- Priority: irq 2 and irq 6 rise in the same cycle -> 6 is taken first; after eret, 2 is taken.
- Nesting: irq 2 in service (ex_pc = 0x200); irq 5 rises with ex_pc = 0x300 -> fires 5, sepc = 0x300; eret -> sepc = 0x200, in_service = 0x04. A lower irq 1 stays pending until the second eret.
- Safe point: request with can_take = 0 for 5 cycles -> FSM holds in WAIT, no pulse; can_take = 1 -> FIRE next cycle with ex_pc captured at that edge.
- Mask/enable: irq 4 pending with mask[4] = 0 -> no fire and pending kept; mask[4] = 1 -> fires. Same check with int_en toggled.
- Reset mid-operation: rstn = 0 while in WAIT with 2 levels nested -> all outputs 0 and stack empty; no fire after reset release without a new edge.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: sequencer states,
// default sizing and the vector stride the next-PC unit uses.
package int_ctrl_pkg;

  localparam int          NUM_IRQ_DEF = 8;
  localparam int          DEPTH_DEF   = 8;
  localparam logic [31:0] VEC_STRIDE  = 32'd24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_e;

  // Vector address of an interrupt id, as computed by the next-PC unit.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] id);
    return base + (id * VEC_STRIDE);
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Signal bundle between the pipeline/next-PC unit and the interrupt controller.
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
);
  localparam int IW = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_in;
  logic               int_en;
  logic [NUM_IRQ-1:0] int_mask;
  logic [31:0]        ex_pc;
  logic               can_take;
  logic               eret;

  logic               int_signal;
  logic [IW-1:0]      int_pend;
  logic [31:0]        sepc;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [NUM_IRQ-1:0] in_service;
  logic               busy;

  modport master (
    output irq_in, int_en, int_mask, ex_pc, can_take, eret,
    input  int_signal, int_pend, sepc, irq_ack, in_service, busy
  );

  modport slave (
    input  irq_in, int_en, int_mask, ex_pc, can_take, eret,
    output int_signal, int_pend, sepc, irq_ack, in_service, busy
  );

endinterface

// File: rtl/int_ctrl_chk.sv
// Protocol checks for the interrupt controller: no push onto a full
// nesting stack and no return pulse while an interrupt is being fired.
module int_ctrl_chk (
  input logic i_clk,
  input logic i_rstn,
  input logic i_push,
  input logic i_full,
  input logic i_eret,
  input logic i_fire
);

  a_no_push_full : assert property (@(posedge i_clk) disable iff (!i_rstn) !(i_push && i_full))
    else $error("int_ctrl: push onto full nesting stack");

  a_no_eret_fire : assert property (@(posedge i_clk) disable iff (!i_rstn) !(i_eret && i_fire))
    else $error("int_ctrl: eret pulse during interrupt fire");

endmodule

// File: rtl/int_prio_enc.sv
// Combinational highest-set-bit encoder returning {valid, index}.
module int_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int W = $clog2(N);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      o_valid = o_valid | i_req[i];
      o_idx   = i_req[i] ? W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches IRQ edges, masks and priority-encodes them,
// fires at a pipeline-safe point and keeps a nesting stack of return PCs.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  int_ctrl_if.slave  bus
);
  localparam int IW = $clog2(NUM_IRQ);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH + 1);

  state_e             r_state;
  state_e             w_next;
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_insvc;
  logic [DW-1:0]      r_depth;
  logic [31:0]        r_stk_pc [DEPTH];
  logic [IW-1:0]      r_stk_id [DEPTH];
  logic [31:0]        r_sepc;
  logic               r_int_signal;
  logic [IW-1:0]      r_int_pend;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic               r_busy;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_onehot;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_best_v;
  logic [IW-1:0]      w_best;
  logic               w_cur_v;
  logic [IW-1:0]      w_cur;
  logic               w_req;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [AW-1:0]      w_wr_idx;
  logic [AW-1:0]      w_top_idx;
  logic [AW-1:0]      w_below_idx;

  assign w_rise   = bus.irq_in & ~r_hist;
  assign w_elig   = bus.int_en ? (r_pend & bus.int_mask) : '0;
  assign w_onehot = NUM_IRQ'(1) << w_best;
  assign w_clr    = w_push ? w_onehot : '0;

  int_prio_enc #(.N(NUM_IRQ)) u_best (.i_req(w_elig),  .o_valid(w_best_v), .o_idx(w_best));
  int_prio_enc #(.N(NUM_IRQ)) u_cur  (.i_req(r_insvc), .o_valid(w_cur_v),  .o_idx(w_cur));

  // Only a strictly higher level may preempt the one currently in service.
  assign w_req = w_best_v && (!w_cur_v || (w_best > w_cur));

  // A return pulse in FIRE is a protocol error and is ignored.
  assign w_pop  = bus.eret && (r_depth != '0) && (r_state != ST_FIRE);
  assign w_full = (r_depth == DW'(DEPTH));

  assign w_wr_idx    = AW'(r_depth);
  assign w_top_idx   = AW'(r_depth - DW'(1));
  assign w_below_idx = AW'(r_depth - DW'(2));

  // Sequencer next state: wait for a safe point, then fire for one cycle.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !bus.eret) w_next = ST_WAIT;
        else                    w_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_next = ST_IDLE;
        end else if (bus.can_take && !bus.eret) begin
          w_next = ST_FIRE;
          w_push = 1'b1;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_FIRE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Edge history and sticky pending bits; a new edge beats a same-cycle take.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_hist <= '0;
      r_pend <= '0;
    end else begin
      r_hist <= bus.irq_in;
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  // Nesting stack of {return PC, id}, in-service map and top-of-stack PC.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_depth <= '0;
      r_insvc <= '0;
      r_sepc  <= 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
        r_stk_pc[k] <= 32'd0;
        r_stk_id[k] <= '0;
      end
    end else if (w_push) begin
      r_stk_pc[w_wr_idx] <= bus.ex_pc;
      r_stk_id[w_wr_idx] <= w_best;
      r_depth            <= r_depth + DW'(1);
      r_insvc            <= r_insvc | w_onehot;
      r_sepc             <= bus.ex_pc;
    end else if (w_pop) begin
      r_depth <= r_depth - DW'(1);
      r_insvc <= r_insvc & ~(NUM_IRQ'(1) << r_stk_id[w_top_idx]);
      r_sepc  <= (r_depth > DW'(1)) ? r_stk_pc[w_below_idx] : 32'd0;
    end else begin
      r_depth <= r_depth;
    end
  end

  // Fire pulse, vector id, acknowledge and busy flag, all registered.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_int_signal <= 1'b0;
      r_int_pend   <= '0;
      r_irq_ack    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_int_signal <= w_push;
      r_int_pend   <= w_push ? w_best : '0;
      r_irq_ack    <= w_push ? w_onehot : '0;
      r_busy       <= (w_next != ST_IDLE);
    end
  end

  assign bus.int_signal = r_int_signal;
  assign bus.int_pend   = r_int_pend;
  assign bus.sepc       = r_sepc;
  assign bus.irq_ack    = r_irq_ack;
  assign bus.in_service = r_insvc;
  assign bus.busy       = r_busy;

  int_ctrl_chk u_chk (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (w_push),
    .i_full (w_full),
    .i_eret (bus.eret),
    .i_fire (r_state == ST_FIRE)
  );

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized
// traffic, each cycle compared against a behavioural reference model.
module tb_int_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  int_ctrl_if #(.NUM_IRQ(8)) bus ();

  int_ctrl #(.NUM_IRQ(8), .DEPTH(8)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: pending bits, IRQ history, return stack, phase
  // (0 = nothing scheduled, 1 = waiting for safe point, 2 = firing).
  bit [7:0]    m_pend;
  bit [7:0]    m_prev;
  int          m_phase;
  logic [31:0] m_pc_q [$];
  int          m_id_q [$];
  bit          m_fire;
  int          m_fire_id;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int best, cur, ph;
    bit req, fire_now;
    bit [7:0] rise, clr;
    if (!rstn) begin
      m_pend = 8'h00; m_prev = 8'h00; m_phase = 0;
      m_pc_q.delete(); m_id_q.delete();
      m_fire = 1'b0; m_fire_id = 0;
      return;
    end
    best = -1;
    for (int i = 0; i < 8; i++)
      if (bus.int_en && m_pend[i] && bus.int_mask[i]) best = i;
    cur = -1;
    foreach (m_id_q[k]) if (m_id_q[k] > cur) cur = m_id_q[k];
    req = (best > cur);
    rise = bus.irq_in & ~m_prev;
    fire_now = 1'b0;
    clr = 8'h00;
    ph = m_phase;
    if (ph == 0) begin
      m_phase = (req && !bus.eret) ? 1 : 0;
    end else if (ph == 1) begin
      if (!req) m_phase = 0;
      else if (bus.can_take && !bus.eret) begin
        fire_now = 1'b1;
        m_phase = 2;
        m_pc_q.push_back(bus.ex_pc);
        m_id_q.push_back(best);
        clr[best] = 1'b1;
      end
    end else begin
      m_phase = 0;
    end
    if (bus.eret && ph != 2 && m_pc_q.size() > 0) begin
      void'(m_pc_q.pop_back());
      void'(m_id_q.pop_back());
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = bus.irq_in;
    m_fire = fire_now;
    m_fire_id = fire_now ? best : 0;
  endtask

  task automatic compare_all();
    logic [31:0] e_sepc;
    logic [7:0]  e_isv;
    e_sepc = (m_pc_q.size() > 0) ? m_pc_q[$] : 32'd0;
    e_isv = 8'h00;
    foreach (m_id_q[k]) e_isv[m_id_q[k]] = 1'b1;
    chk_eq("int_signal", {31'd0, bus.int_signal}, {31'd0, m_fire});
    chk_eq("int_pend",   32'(bus.int_pend), 32'(m_fire_id));
    chk_eq("irq_ack",    32'(bus.irq_ack), m_fire ? (32'd1 << m_fire_id) : 32'd0);
    chk_eq("sepc",       bus.sepc, e_sepc);
    chk_eq("in_service", 32'(bus.in_service), 32'(e_isv));
    chk_eq("busy",       {31'd0, bus.busy}, (m_phase != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    bus.irq_in = v;
    tick();
    bus.irq_in = 8'h00;
  endtask

  task automatic wait_fire(input string tag);
    int n;
    n = 0;
    while (bus.int_signal !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.int_signal !== 1'b1) chk_eq(tag, {31'd0, bus.int_signal}, 32'd1);
  endtask

  task automatic do_eret();
    while (m_phase == 2) tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.irq_in = 8'h00; bus.int_en = 1'b1; bus.int_mask = 8'hFF;
    bus.ex_pc = 32'h0; bus.can_take = 1'b1; bus.eret = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Single IRQ: fires two cycles after the pending bit is set.
    bus.ex_pc = 32'h100;
    pulse_irq(8'h08);
    tick();
    tick();
    chk_eq("t1_sig",  {31'd0, bus.int_signal}, 32'd1);
    chk_eq("t1_pend", 32'(bus.int_pend), 32'd3);
    chk_eq("t1_ack",  32'(bus.irq_ack), 32'h08);
    chk_eq("t1_sepc", bus.sepc, 32'h100);
    chk_eq("t1_isv",  32'(bus.in_service), 32'h08);
    tick();
    do_eret();
    chk_eq("t1_sepc_ret", bus.sepc, 32'h0);
    chk_eq("t1_isv_ret",  32'(bus.in_service), 32'h0);

    // Priority: simultaneous 2 and 6, 6 first then 2.
    pulse_irq(8'h44);
    wait_fire("t2_fire6");
    chk_eq("t2_first", 32'(bus.int_pend), 32'd6);
    do_eret();
    wait_fire("t2_fire2");
    chk_eq("t2_second", 32'(bus.int_pend), 32'd2);
    do_eret();

    // Nesting: 2 in service, 5 preempts, 1 waits until both return.
    bus.ex_pc = 32'h200;
    pulse_irq(8'h04);
    wait_fire("t3_fire2");
    chk_eq("t3_lvl2", 32'(bus.int_pend), 32'd2);
    bus.ex_pc = 32'h300;
    pulse_irq(8'h22);
    wait_fire("t3_fire5");
    chk_eq("t3_lvl5",  32'(bus.int_pend), 32'd5);
    chk_eq("t3_sepc5", bus.sepc, 32'h300);
    chk_eq("t3_isv",   32'(bus.in_service), 32'h24);
    repeat (4) tick();
    do_eret();
    chk_eq("t3_sepc_pop", bus.sepc, 32'h200);
    chk_eq("t3_isv_pop",  32'(bus.in_service), 32'h04);
    repeat (5) tick();
    chk_eq("t3_hold1", {31'd0, bus.int_signal}, 32'd0);
    do_eret();
    wait_fire("t3_fire1");
    chk_eq("t3_lvl1", 32'(bus.int_pend), 32'd1);
    do_eret();

    // Safe point: hold in WAIT until can_take, capture ex_pc at that edge.
    bus.can_take = 1'b0;
    pulse_irq(8'h10);
    repeat (6) tick();
    chk_eq("t4_busy", {31'd0, bus.busy}, 32'd1);
    chk_eq("t4_nosig", {31'd0, bus.int_signal}, 32'd0);
    bus.ex_pc = 32'h444;
    bus.can_take = 1'b1;
    tick();
    chk_eq("t4_sig",  {31'd0, bus.int_signal}, 32'd1);
    chk_eq("t4_sepc", bus.sepc, 32'h444);
    do_eret();

    // Mask and global enable keep the request pending without firing.
    bus.int_mask = 8'hEF;
    pulse_irq(8'h10);
    repeat (5) tick();
    chk_eq("t5_mask_nosig", {31'd0, bus.int_signal}, 32'd0);
    chk_eq("t5_mask_idle",  {31'd0, bus.busy}, 32'd0);
    bus.int_mask = 8'hFF;
    wait_fire("t5_mask_fire");
    chk_eq("t5_mask_id", 32'(bus.int_pend), 32'd4);
    do_eret();
    bus.int_en = 1'b0;
    pulse_irq(8'h10);
    repeat (5) tick();
    chk_eq("t5_en_nosig", {31'd0, bus.int_signal}, 32'd0);
    bus.int_en = 1'b1;
    wait_fire("t5_en_fire");
    chk_eq("t5_en_id", 32'(bus.int_pend), 32'd4);
    do_eret();

    // Reset while waiting with two levels nested.
    bus.ex_pc = 32'h600;
    pulse_irq(8'h08);
    wait_fire("t6_fire3");
    pulse_irq(8'h40);
    wait_fire("t6_fire6");
    bus.can_take = 1'b0;
    pulse_irq(8'h80);
    tick();
    tick();
    chk_eq("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    rstn = 1'b0;
    tick();
    chk_eq("t6_sig",  {31'd0, bus.int_signal}, 32'd0);
    chk_eq("t6_pend", 32'(bus.int_pend), 32'd0);
    chk_eq("t6_sepc", bus.sepc, 32'd0);
    chk_eq("t6_ack",  32'(bus.irq_ack), 32'd0);
    chk_eq("t6_isv",  32'(bus.in_service), 32'd0);
    chk_eq("t6_busy", {31'd0, bus.busy}, 32'd0);
    rstn = 1'b1;
    bus.can_take = 1'b1;
    repeat (6) tick();
    chk_eq("t6_nofire", {31'd0, bus.busy}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) bus.irq_in[b] = ~bus.irq_in[b];
      if ($urandom_range(0, 31) == 0) bus.int_mask = 8'($urandom);
      else if ($urandom_range(0, 15) == 0) bus.int_mask = 8'hFF;
      if ($urandom_range(0, 39) == 0) bus.int_en = ~bus.int_en;
      bus.can_take = ($urandom_range(0, 3) != 0);
      bus.eret = (m_phase != 2) && ($urandom_range(0, 9) == 0);
      bus.ex_pc = $urandom;
      rstn = ($urandom_range(0, 499) != 0);
      tick();
    end
    bus.eret = 1'b0;
    rstn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
